// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe_if
// Description : Valid/ready operand and result channels of logic_unit_pipe.
//               master = producer of operand beats / consumer of results.
//               slave  = the logic unit itself.
// Signals     : in_valid/in_ready handshake, in_op[2:0], in_acc, in_last,
//               in_a/in_b[WIDTH], out_valid/out_ready handshake,
//               out_r[WIDTH], out_zero, out_count[CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_unit_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_acc;
  logic             in_last;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic             out_zero;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_op, in_acc, in_last, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_r, out_zero, out_count
  );

  modport slave (
    input  in_valid, in_op, in_acc, in_last, in_a, in_b, out_ready,
    output in_ready, out_valid, out_r, out_zero, out_count
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Pipelined bitwise logic unit with one-cycle latency and an
//               optional accumulate mode that folds a burst of operands into
//               a single result using the operation latched at burst start.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - logic_unit_pipe_if.slave (operand + result channels)
// Parameters  : WIDTH  - operand/result width (1..64)
//               CNT_W  - beat counter width (count saturates at all-ones)
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  wire                 clk,
  input  wire                 rst_n,
  logic_unit_pipe_if.slave    bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'b000:  res = x & y;
      3'b001:  res = x | y;
      3'b010:  res = x ^ y;
      3'b011:  res = ~(x & y);
      3'b100:  res = ~(x | y);
      3'b101:  res = ~(x ^ y);
      3'b110:  res = x & ~y;
      default: res = x;
    endcase
    return res;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_burst_op;
  logic [2:0]       w_burst_op_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_r;
  logic             r_out_zero;
  logic [CNT_W-1:0] r_out_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_load_out;
  logic [WIDTH-1:0] w_out_val;
  logic [CNT_W-1:0] w_out_cnt;
  logic [WIDTH-1:0] w_fold;
  logic [CNT_W-1:0] w_cnt_inc;

  // A new beat may enter whenever the output register is empty or is being
  // drained this cycle; every beat may produce a result so no finer gating.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_fold    = f_logic_op(r_burst_op, r_acc, bus.in_a);
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

  // Next-state / datapath control
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_burst_op_nxt = r_burst_op;
    w_load_out     = 1'b0;
    w_out_val      = '0;
    w_out_cnt      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.in_acc && !bus.in_last) begin
            w_burst_op_nxt = bus.in_op;
            w_acc_nxt      = f_logic_op(bus.in_op, bus.in_a, bus.in_b);
            w_cnt_nxt      = c_CNT_ONE;
            w_state_nxt    = S_ACCUM;
          end else begin
            // Plain beat or single-beat burst: result straight out.
            w_load_out = 1'b1;
            w_out_val  = f_logic_op(bus.in_op, bus.in_a, bus.in_b);
            w_out_cnt  = c_CNT_ONE;
          end
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          // Burst continuation: only in_a and in_last matter here.
          w_acc_nxt = w_fold;
          w_cnt_nxt = w_cnt_inc;
          if (bus.in_last) begin
            w_load_out  = 1'b1;
            w_out_val   = w_fold;
            w_out_cnt   = w_cnt_inc;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_burst_op <= 3'b000;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_burst_op <= w_burst_op_nxt;
    end
  end

  // Output register: a new result takes priority over draining, so a
  // back-to-back result keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_zero  <= 1'b0;
      r_out_count <= '0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_r     <= w_out_val;
      r_out_zero  <= (w_out_val == '0);
      r_out_count <= w_out_cnt;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_r     = r_out_r;
  assign bus.out_zero  = r_out_zero;
  assign bus.out_count = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe. Main instance is
//               WIDTH=32/CNT_W=8 with a result scoreboard; a second instance
//               WIDTH=8/CNT_W=2 exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  typedef struct {
    logic [31:0] r;
    logic        zero;
    logic [7:0]  cnt;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  logic_unit_pipe_if #(.WIDTH(32), .CNT_W(8)) bus  ();
  logic_unit_pipe_if #(.WIDTH(8),  .CNT_W(2)) bus2 ();

  logic_unit_pipe #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] r, input logic [7:0] cnt);
    exp_t e;
    e.r = r; e.zero = (r == 32'h0); e.cnt = cnt; e.tag = tag;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic acc, input logic last,
                      input logic [31:0] a, input logic [31:0] b);
    bit accepted;
    accepted = 0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_acc = acc;
    bus.in_last = last;  bus.in_a = a;  bus.in_b = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin accepted = 1; break; end
    end
    if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Result monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_r"},     64'(bus.out_r),     64'(e.r));
        check({e.tag, "_zero"},  64'(bus.out_zero),  64'(e.zero));
        check({e.tag, "_count"}, 64'(bus.out_count), 64'(e.cnt));
      end
    end
  end

  logic [31:0] sweep_exp [8];
  logic [7:0]  bytes2 [5];

  initial begin
    errors = 0; checks = 0;
    sweep_exp = '{32'hAAAA_0000, 32'hFFFF_5555, 32'h5555_5555, 32'h5555_FFFF,
                  32'h0000_AAAA, 32'hAAAA_AAAA, 32'h0000_5555, 32'hAAAA_5555};
    bytes2 = '{8'h01, 8'h02, 8'h04, 8'h10, 8'h80};
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_op = 0; bus.in_acc = 0; bus.in_last = 0;
    bus.in_a = 0; bus.in_b = 0; bus.out_ready = 1'b1;
    bus2.in_valid = 0; bus2.in_op = 0; bus2.in_acc = 0; bus2.in_last = 0;
    bus2.in_a = 0; bus2.in_b = 0; bus2.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_r",     64'(bus.out_r),     64'd0);
    check("rst_zero",  64'(bus.out_zero),  64'd0);
    check("rst_count", 64'(bus.out_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single AND
    push("and_single", 32'h00F0_1234, 8'd1);
    send(3'b000, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check("and_latency_valid", 64'(bus.out_valid), 64'd1);

    // All eight ops back-to-back, then NAND giving zero
    for (int k = 0; k < 8; k++) begin
      push($sformatf("sweep_op%0d", k), sweep_exp[k], 8'd1);
      send(3'(k), 1'b0, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000);
    end
    push("nand_zero", 32'h0, 8'd1);
    send(3'b011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Single-beat burst (acc=1, last=1) behaves like a plain beat
    push("acc_single", 32'h0000_0006, 8'd1);
    send(3'b010, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0003);

    // XOR burst
    push("xor_burst", 32'h0000_000F, 8'd3);
    send(3'b010, 1'b1, 1'b0, 32'h1, 32'h2);
    check("burst_valid_b1", 64'(bus.out_valid), 64'd0);
    send(3'b000, 1'b0, 1'b0, 32'h4, 32'hFFFF_FFFF);
    check("burst_valid_b2", 64'(bus.out_valid), 64'd0);
    send(3'b111, 1'b1, 1'b1, 32'h8, 32'h0);
    check("burst_valid_b3", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    check("drain_valid_low", 64'(bus.out_valid), 64'd0);

    // Backpressure
    bus.out_ready = 1'b0;
    push("bp_first", 32'h3, 8'd1);
    send(3'b001, 1'b0, 1'b0, 32'h1, 32'h2);
    push("bp_second", 32'h0F, 8'd1);
    bus.in_valid = 1'b1; bus.in_op = 3'b000; bus.in_acc = 1'b0;
    bus.in_last = 1'b0; bus.in_a = 32'hFF; bus.in_b = 32'h0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready),  64'd0);
      check("bp_valid",    64'(bus.out_valid), 64'd1);
      check("bp_hold_r",   64'(bus.out_r),     64'h3);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_rise", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_second_valid", 64'(bus.out_valid), 64'd1);
    check("bp_second_r",     64'(bus.out_r),     64'h0F);
    @(posedge clk); #1;

    // Reset mid-burst
    send(3'b001, 1'b1, 1'b0, 32'h10, 32'h20);
    send(3'b000, 1'b0, 1'b0, 32'h40, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_r",     64'(bus.out_r),     64'd0);
    check("mid_rst_zero",  64'(bus.out_zero),  64'd0);
    check("mid_rst_count", 64'(bus.out_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push("post_rst_or", 32'h7, 8'd1);
    send(3'b001, 1'b0, 1'b0, 32'h3, 32'h4);
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);

    // Narrow instance: 5-beat OR burst saturates the 2-bit count
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1'b1; bus2.in_op = 3'b001; bus2.in_acc = 1'b1;
      bus2.in_last = (i == 4); bus2.in_a = bytes2[i]; bus2.in_b = 8'h00;
      @(negedge clk);
      check("w8_in_ready", 64'(bus2.in_ready), 64'd1);
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      check($sformatf("w8_valid_b%0d", i), 64'(bus2.out_valid), 64'(i == 4));
    end
    check("w8_r",     64'(bus2.out_r),     64'h97);
    check("w8_count", 64'(bus2.out_count), 64'd3);
    check("w8_zero",  64'(bus2.out_zero),  64'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 8, giving the beat-counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand beat is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-007 SHALL have port in_op, input, 3 bits: operation code.
REQ-008 SHALL have port in_acc, input, 1 bit: the beat opens an accumulate burst.
REQ-009 SHALL have port in_last, input, 1 bit: final beat of a burst.
REQ-010 SHALL have ports in_a and in_b, input, WIDTH bits each: operands.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out_r, output, WIDTH bits: the result.
REQ-014 SHALL have port out_zero, output, 1 bit: out_r equals all zeros.
REQ-015 SHALL have port out_count, output, CNT_W bits: number of beats folded into out_r.

Function
REQ-016 SHALL decode in_op as follows:
- 000: AND
- 001: OR
- 010: XOR
- 011: NAND
- 100: NOR
- 101: XNOR
- 110: ANDN (x & ~y)
- 111: PASS (x)

REQ-017 SHALL accept a beat on any cycle where in_valid and in_ready are both 1.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-019 SHALL implement a two-state FSM:
- IDLE: no burst open.
- ACCUM: burst open.

REQ-020 In IDLE, a beat accepted with in_acc=0 SHALL set, on the next edge:
- out_r = op(in_a, in_b)
- out_count = 1
- out_valid = 1
- state stays IDLE
- in_last is ignored.

REQ-021 In IDLE, a beat accepted with in_acc=1 and in_last=0 SHALL, on the next edge:
- latch in_op as burst_op
- set acc = op(in_a, in_b) and cnt = 1
- move to ACCUM.

REQ-022 In IDLE, a beat accepted with in_acc=1 and in_last=1 SHALL behave as REQ-020 (a single-beat burst).
REQ-023 In ACCUM, each accepted beat SHALL:
- compute acc = burst_op(acc, in_a)
- ignore in_b, in_op and in_acc
- increment cnt, saturating at 2^CNT_W-1.

REQ-024 In ACCUM, a beat accepted with in_last=1 SHALL, on the next edge:
- load out_r with the folded value and out_count with the updated cnt
- set out_valid = 1
- return the FSM to IDLE.

REQ-025 Latency SHALL be one cycle from the accepting edge to out_valid=1 for single beats and for last beats.
REQ-026 out_valid SHALL stay 1 and out_r, out_zero and out_count SHALL stay stable until the cycle in which out_ready=1.
REQ-027 When out_valid=1, out_ready=1 and a result-producing beat is accepted in the same cycle, the output register SHALL load the new result and out_valid SHALL stay 1.
REQ-028 When out_valid=1, out_ready=1 and no result-producing beat is accepted, out_valid SHALL go to 0 on the next edge.
REQ-029 out_zero SHALL be registered alongside out_r and SHALL equal (out_r == 0).
REQ-030 Operations SHALL be purely bitwise, with no carry between bit positions, for any WIDTH.

Reset
REQ-031 While rst_n=0 the block SHALL hold:
- out_valid = 0
- out_r = 0
- out_zero = 0
- out_count = 0
- FSM in IDLE
- acc = 0, cnt = 0, burst_op = 0.

REQ-032 Reset asserted mid-burst SHALL discard the burst, and any unconsumed output is lost.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 and the first beat SHALL be accepted on the first rising edge.

Verification
REQ-034 Single AND, WIDTH=32: op=000, a=0xF0F0_1234, b=0x0FF0_FFFF, out_ready=1 -> next cycle out_r=0x00F0_1234, out_zero=0, out_count=1.
REQ-035 All eight ops: sweep with a=0xAAAA_5555, b=0xFFFF_0000 -> each out_r matches REQ-016 exactly; NAND of a=b=0xFFFF_FFFF gives out_r=0 and out_zero=1.
REQ-036 XOR burst: in_acc=1, op=010, beats (a,b) = (0x1,0x2), then a=0x4, then a=0x8 with in_last=1 -> out_r=0xF and out_count=3, with out_valid only after the third beat.
REQ-037 Backpressure: out_ready held 0 while a second beat is offered -> in_ready=0, the first result stays stable, and the second is accepted on the cycle out_ready rises and appears one cycle later.
REQ-038 Reset mid-burst: assert rst_n=0 after two accumulate beats -> all outputs are 0, and a following single OR beat (0x3, 0x4) gives out_r=0x7 and out_count=1.
REQ-039 Parameters WIDTH=8, CNT_W=2: a 5-beat OR burst -> out_count saturates at 3 and out_r is the 8-bit OR of all beats.
